// File: rtl/hc_rx_port_dispatcher.sv
// Receive-side dispatcher: buffers HC RX port bytes in a small FIFO and hands them
// to whichever client (getPacket or directCntl) currently holds the RX grant.
module hc_rx_port_dispatcher #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] RxPortData,
    input  logic [7:0] RxPortCntl,
    input  logic       RxPortRdy,
    input  logic       getPacketReq,
    output logic       getPacketGnt,
    output logic       getPacketRdy,
    input  logic       getPacketAck,
    input  logic       directCntlReq,
    output logic       directCntlGnt,
    output logic       directCntlRdy,
    input  logic       directCntlAck,
    output logic [7:0] rxData,
    output logic [7:0] rxCntl,
    output logic       rxOverflow,
    output logic       rxDropped
);

    localparam int unsigned CW = FIFO_AW + 1;
    localparam int unsigned EW = 16;

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_GNT_PKT = 3'd2,
        ST_GNT_DIR = 3'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 pkt_gnt_q, pkt_gnt_d;
    logic                 dir_gnt_q, dir_gnt_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 dropped_q, dropped_d;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        mem_d [FIFO_DEPTH];

    logic owner_req;
    logic release_c;
    logic pop_c;
    logic push_c;
    logic full_c;

    assign getPacketGnt  = pkt_gnt_q;
    assign directCntlGnt = dir_gnt_q;
    assign getPacketRdy  = pkt_gnt_q & (count_q != '0);
    assign directCntlRdy = dir_gnt_q & (count_q != '0);
    assign rxData        = mem_q[rd_ptr_q][15:8];
    assign rxCntl        = mem_q[rd_ptr_q][7:0];
    assign rxOverflow    = overflow_q;
    assign rxDropped     = dropped_q;

    // Grant FSM plus FIFO bookkeeping; a release cycle flushes instead of pushing/popping
    always_comb begin
        state_d    = state_q;
        pkt_gnt_d  = pkt_gnt_q;
        dir_gnt_d  = dir_gnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = 1'b0;
        dropped_d  = 1'b0;
        mem_d      = mem_q;
        push_c     = 1'b0;

        owner_req = ((state_q == ST_GNT_PKT) && getPacketReq) ||
                    ((state_q == ST_GNT_DIR) && directCntlReq);
        release_c = ((state_q == ST_GNT_PKT) && !getPacketReq) ||
                    ((state_q == ST_GNT_DIR) && !directCntlReq);
        pop_c     = (getPacketRdy && getPacketAck) || (directCntlRdy && directCntlAck);
        full_c    = (count_q == CW'(FIFO_DEPTH));

        case (state_q)
            ST_START: state_d = ST_IDLE;
            ST_IDLE: begin
                if (getPacketReq) begin
                    state_d   = ST_GNT_PKT;
                    pkt_gnt_d = 1'b1;
                end else if (directCntlReq) begin
                    state_d   = ST_GNT_DIR;
                    dir_gnt_d = 1'b1;
                end
            end
            ST_GNT_PKT: begin
                if (!getPacketReq) begin
                    state_d   = ST_IDLE;
                    pkt_gnt_d = 1'b0;
                end
            end
            ST_GNT_DIR: begin
                if (!directCntlReq) begin
                    state_d   = ST_IDLE;
                    dir_gnt_d = 1'b0;
                end
            end
            default: state_d = ST_START;
        endcase

        if (release_c) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else if (owner_req) begin
            push_c     = RxPortRdy && (!full_c || pop_c);
            overflow_d = RxPortRdy && full_c && !pop_c;
            if (push_c) begin
                mem_d[wr_ptr_q] = {RxPortData, RxPortCntl};
                wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CW'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CW'(1);
            end
        end

        dropped_d = RxPortRdy && !owner_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_START;
            pkt_gnt_q  <= 1'b0;
            dir_gnt_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pkt_gnt_q  <= pkt_gnt_d;
            dir_gnt_q  <= dir_gnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_hc_rx_port_dispatcher.sv
// Directed bench for hc_rx_port_dispatcher: grant arbitration, FIFO ordering,
// overflow/drop pulses, release flush and mid-transfer reset.
module tb_hc_rx_port_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] RxPortData;
    logic [7:0] RxPortCntl;
    logic       RxPortRdy;
    logic       getPacketReq;
    logic       getPacketGnt;
    logic       getPacketRdy;
    logic       getPacketAck;
    logic       directCntlReq;
    logic       directCntlGnt;
    logic       directCntlRdy;
    logic       directCntlAck;
    logic [7:0] rxData;
    logic [7:0] rxCntl;
    logic       rxOverflow;
    logic       rxDropped;

    int checks = 0;
    int errors = 0;

    hc_rx_port_dispatcher #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk(clk), .rst(rst),
        .RxPortData(RxPortData), .RxPortCntl(RxPortCntl), .RxPortRdy(RxPortRdy),
        .getPacketReq(getPacketReq), .getPacketGnt(getPacketGnt),
        .getPacketRdy(getPacketRdy), .getPacketAck(getPacketAck),
        .directCntlReq(directCntlReq), .directCntlGnt(directCntlGnt),
        .directCntlRdy(directCntlRdy), .directCntlAck(directCntlAck),
        .rxData(rxData), .rxCntl(rxCntl),
        .rxOverflow(rxOverflow), .rxDropped(rxDropped)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        RxPortData = 8'h00; RxPortCntl = 8'h00; RxPortRdy = 1'b0;
        getPacketReq = 1'b0; getPacketAck = 1'b0;
        directCntlReq = 1'b0; directCntlAck = 1'b0;
        tick();
        tick();
        checks++;
        if ({getPacketGnt, getPacketRdy, directCntlGnt, directCntlRdy, rxOverflow, rxDropped} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {getPacketGnt, getPacketRdy, directCntlGnt, directCntlRdy, rxOverflow, rxDropped});
        end
        checks++;
        if ({rxData, rxCntl} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data got %h want 0000", {rxData, rxCntl});
        end
    endtask

    task automatic test_priority();
        rst = 1'b0;
        getPacketReq = 1'b1;
        directCntlReq = 1'b1;
        tick();
        checks++;
        if (getPacketGnt !== 1'b0 || directCntlGnt !== 1'b0) begin
            errors++;
            $display("FAIL start_no_gnt got %b%b want 00", getPacketGnt, directCntlGnt);
        end
        tick();
        checks++;
        if (getPacketGnt !== 1'b1 || directCntlGnt !== 1'b0) begin
            errors++;
            $display("FAIL priority_gnt got pkt=%b dir=%b want pkt=1 dir=0", getPacketGnt, directCntlGnt);
        end
    endtask

    task automatic test_hold_ack();
        RxPortRdy = 1'b1; RxPortData = 8'hA5; RxPortCntl = 8'h01;
        tick();
        RxPortRdy = 1'b0;
        checks++;
        if (getPacketRdy !== 1'b1 || rxData !== 8'hA5 || rxCntl !== 8'h01 || directCntlRdy !== 1'b0) begin
            errors++;
            $display("FAIL first_byte got rdy=%b data=%h cntl=%h drdy=%b want 1 a5 01 0",
                     getPacketRdy, rxData, rxCntl, directCntlRdy);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (getPacketRdy !== 1'b1 || rxData !== 8'hA5) begin
                errors++;
                $display("FAIL hold_stable[%0d] got rdy=%b data=%h want 1 a5", i, getPacketRdy, rxData);
            end
        end
        getPacketAck = 1'b1;
        tick();
        getPacketAck = 1'b0;
        checks++;
        if (getPacketRdy !== 1'b0) begin
            errors++;
            $display("FAIL ack_pop got rdy=%b want 0", getPacketRdy);
        end
        // hand the stream over to the waiting directCntl
        getPacketReq = 1'b0;
        tick();
        checks++;
        if (getPacketGnt !== 1'b0 || directCntlGnt !== 1'b0) begin
            errors++;
            $display("FAIL pkt_release got %b%b want 00", getPacketGnt, directCntlGnt);
        end
        tick();
        checks++;
        if (directCntlGnt !== 1'b1 || directCntlRdy !== 1'b0) begin
            errors++;
            $display("FAIL dir_gnt got gnt=%b rdy=%b want 1 0", directCntlGnt, directCntlRdy);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            RxPortRdy = 1'b1; RxPortData = 8'(8'h10 + i); RxPortCntl = 8'(i);
            tick();
            checks++;
            if (rxOverflow !== (i == 4)) begin
                errors++;
                $display("FAIL overflow[%0d] got %b want %b", i, rxOverflow, (i == 4));
            end
        end
        RxPortRdy = 1'b0;
        tick();
        checks++;
        if (rxOverflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pulse got %b want 0", rxOverflow);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (directCntlRdy !== 1'b1 || rxData !== 8'(8'h10 + i) || rxCntl !== 8'(i)) begin
                errors++;
                $display("FAIL drain[%0d] got rdy=%b data=%h cntl=%h want 1 %h %h",
                         i, directCntlRdy, rxData, rxCntl, 8'(8'h10 + i), 8'(i));
            end
            directCntlAck = 1'b1;
            tick();
            directCntlAck = 1'b0;
        end
        checks++;
        if (directCntlRdy !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got rdy=%b want 0", directCntlRdy);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp [4];
        exp[0] = 8'h31; exp[1] = 8'h32; exp[2] = 8'h33; exp[3] = 8'h20;
        for (int i = 0; i < 4; i++) begin
            RxPortRdy = 1'b1; RxPortData = 8'(8'h30 + i); RxPortCntl = 8'hC0;
            tick();
        end
        RxPortRdy = 1'b0;
        getPacketAck = 1'b1;
        tick();
        getPacketAck = 1'b0;
        checks++;
        if (rxData !== 8'h30 || directCntlRdy !== 1'b1 || getPacketRdy !== 1'b0) begin
            errors++;
            $display("FAIL nonowner_ack got data=%h drdy=%b prdy=%b want 30 1 0",
                     rxData, directCntlRdy, getPacketRdy);
        end
        directCntlAck = 1'b1;
        RxPortRdy = 1'b1; RxPortData = 8'h20; RxPortCntl = 8'hC1;
        tick();
        directCntlAck = 1'b0;
        RxPortRdy = 1'b0;
        checks++;
        if (rxOverflow !== 1'b0 || rxData !== 8'h31) begin
            errors++;
            $display("FAIL full_push_pop got ovf=%b data=%h want 0 31", rxOverflow, rxData);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (directCntlRdy !== 1'b1 || rxData !== exp[i]) begin
                errors++;
                $display("FAIL full_drain[%0d] got rdy=%b data=%h want 1 %h", i, directCntlRdy, rxData, exp[i]);
            end
            directCntlAck = 1'b1;
            tick();
            directCntlAck = 1'b0;
        end
        checks++;
        if (directCntlRdy !== 1'b0) begin
            errors++;
            $display("FAIL full_drain_empty got rdy=%b want 0", directCntlRdy);
        end
    endtask

    task automatic test_drop_release();
        directCntlReq = 1'b0;
        tick();
        checks++;
        if (directCntlGnt !== 1'b0) begin
            errors++;
            $display("FAIL dir_release got %b want 0", directCntlGnt);
        end
        RxPortRdy = 1'b1; RxPortData = 8'h55; RxPortCntl = 8'h00;
        tick();
        RxPortRdy = 1'b0;
        checks++;
        if (rxDropped !== 1'b1 || getPacketRdy !== 1'b0 || directCntlRdy !== 1'b0) begin
            errors++;
            $display("FAIL idle_drop got drop=%b prdy=%b drdy=%b want 1 0 0", rxDropped, getPacketRdy, directCntlRdy);
        end
        tick();
        checks++;
        if (rxDropped !== 1'b0) begin
            errors++;
            $display("FAIL drop_pulse got %b want 0", rxDropped);
        end
        getPacketReq = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            RxPortRdy = 1'b1; RxPortData = 8'(8'h60 + i); RxPortCntl = 8'h00;
            tick();
        end
        RxPortRdy = 1'b0;
        checks++;
        if (getPacketRdy !== 1'b1 || rxData !== 8'h60) begin
            errors++;
            $display("FAIL pre_release got rdy=%b data=%h want 1 60", getPacketRdy, rxData);
        end
        // byte arriving in the release cycle is dropped too
        getPacketReq = 1'b0;
        RxPortRdy = 1'b1; RxPortData = 8'h66;
        tick();
        RxPortRdy = 1'b0;
        checks++;
        if (getPacketGnt !== 1'b0 || getPacketRdy !== 1'b0 || rxDropped !== 1'b1) begin
            errors++;
            $display("FAIL release_flush got gnt=%b rdy=%b drop=%b want 0 0 1", getPacketGnt, getPacketRdy, rxDropped);
        end
        getPacketReq = 1'b1;
        tick();
        checks++;
        if (getPacketGnt !== 1'b1 || getPacketRdy !== 1'b0) begin
            errors++;
            $display("FAIL regrant_empty got gnt=%b rdy=%b want 1 0", getPacketGnt, getPacketRdy);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            RxPortRdy = 1'b1; RxPortData = 8'(8'h40 + i); RxPortCntl = 8'h0F;
            tick();
        end
        RxPortRdy = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if ({getPacketGnt, getPacketRdy, directCntlGnt, directCntlRdy, rxOverflow, rxDropped, rxData, rxCntl} !== 22'b0) begin
            errors++;
            $display("FAIL mid_reset got gnt=%b rdy=%b data=%h cntl=%h want 0 0 00 00",
                     getPacketGnt, getPacketRdy, rxData, rxCntl);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (getPacketGnt !== 1'b1 || getPacketRdy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_gnt got gnt=%b rdy=%b want 1 0", getPacketGnt, getPacketRdy);
        end
        RxPortRdy = 1'b1; RxPortData = 8'h77; RxPortCntl = 8'h07;
        tick();
        RxPortRdy = 1'b0;
        checks++;
        if (getPacketRdy !== 1'b1 || rxData !== 8'h77 || rxCntl !== 8'h07) begin
            errors++;
            $display("FAIL post_reset_push got rdy=%b data=%h cntl=%h want 1 77 07", getPacketRdy, rxData, rxCntl);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_hold_ack();
        test_overflow();
        test_full_push_pop();
        test_drop_release();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
